ram_bist_ctrl: RTL and testbench
================================

# ram_bist_ctrl

Synthesizable built-in self-test controller for the `dual_port_ram` block. It drives the RAM's write port (`we`, `we_addr`, `din`) and read port (`re`, `re_addr`) and checks `dout`, replacing bench-driven stimulus with an on-chip sequencer. A single `start` pulse runs a four-phase write/verify/write-inverse/verify sweep over every address. The block reports pass/fail and the first failing address, phase and data.

## Interface
- `ADDR_W`, 4, RAM address width; DEPTH = 2^ADDR_W
- `DATA_W`, 8, RAM data width; must be ≥ ADDR_W
- `RD_LAT`, 1, cycles from the RAM sampling `re`/`re_addr` to valid `dout`; legal 1..4

- `clk` in 1: single clock for the controller and RAM
- `reset` in 1: synchronous, active-high
- `start` in 1: begin test; sampled only in IDLE or DONE
- `seed` in DATA_W: pattern seed, captured on the accepted `start`
- `busy` out 1: test in progress
- `done` out 1: test finished; held until the next accepted `start` or `reset`
- `pass` out 1: valid while `done`=1; 1 = no mismatch
- `fail_addr` out ADDR_W: address of the first mismatch
- `fail_phase` out 1: 0 = first verify pass, 1 = inverse verify pass
- `fail_data` out DATA_W: `dout` value seen at the first mismatch
- `ram_we` out 1, `ram_we_addr` out ADDR_W, `ram_din` out DATA_W: drive the RAM write port
- `ram_re` out 1, `ram_re_addr` out ADDR_W: drive the RAM read port
- `ram_dout` in DATA_W: RAM read data

## Operation
- **States:** IDLE → WR0 → RD0 → DRN0 → WR1 → RD1 → DRN1 → DONE. DONE returns to WR0 on `start`.
- **Patterns:** P0(a) = seed_q XOR zero_extend(a); P1(a) = ~P0(a).
- **WR0/WR1:** assert `ram_we`=1 for DEPTH cycles, addresses 0..DEPTH-1 ascending, with `ram_din`=P0 or P1.
- **RD0/RD1:** assert `ram_re`=1 for DEPTH cycles, addresses ascending. A valid/expected/address shift pipeline of depth RD_LAT travels alongside each read.
- **DRN0/DRN1:** RD_LAT cycles with `ram_re`=`ram_we`=0 to let the last read drain.
- **Compare:** on every edge where the pipeline output is valid, compare `ram_dout` against the expected value.
  - On the first mismatch, latch `fail_addr`, `fail_phase` and `fail_data`.
  - Later mismatches are ignored; the test always runs to completion.
- **Write/read overlap:** `ram_we` and `ram_re` are never high in the same cycle.
- **Idle drive:** address and data outputs are 0 whenever the corresponding enable is 0.
- **Start handling:** `start` in WR*/RD*/DRN* is ignored. `start` in DONE clears the result registers and re-runs the test with the new `seed`.
- **Address counter:** wraps from DEPTH-1 to 0 exactly at each phase change; there is no extra write or read.

## Timing
- **Reset values:** all outputs are 0, including `pass`, `done`, `busy`, every `ram_*` output and every `fail_*` output. State is IDLE and the pipeline is cleared.
- **Reset mid-test:** `reset` during any state aborts on that edge. No further `ram_we`/`ram_re` is issued, and the block does not re-run until a new `start`.
- **Start:** accepted on edge E0. `busy`=1 from E0, and `done`=0 and `pass`=0 from E0.
- **WR0:** writes are issued on edges E1..E_DEPTH.
- **RD0:** reads are issued on the next DEPTH edges. The read issued at edge Ek is compared at edge Ek+RD_LAT.
- **Completion:** the final compare and the DONE entry happen on edge E(4·DEPTH+2·RD_LAT). At that edge `busy`→0, `done`→1, and `pass` = no mismatch latched, including a mismatch on that final compare.
- **Defaults:** with the default parameters, `done` rises at E66.

## Test plan
- **Healthy RAM, seed 0x00:** start → writes 0x00..0x0F then 0xFF..0xF0; `done`=1 and `pass`=1 at E66; `fail_addr`=0.
- **Pattern check, seed 0xA5:** monitor shows address 3 written 0xA6 in WR0 and 0x59 in WR1; `pass`=1.
- **Stuck-at fault, seed 0x00:** RAM model with bit 3 at address 5 stuck-0 → `pass`=0, `fail_addr`=5, `fail_phase`=1, `fail_data`=0xF2.
- **Multiple faults:** faults at addresses 2 (phase 0) and 9 → `fail_addr`=2, `fail_phase`=0; `done` still at E66.
- **Start while busy:** pulse `start` at E20 with seed 0x3C → no restart, `done` at E66 and the data still uses the original seed.
- **Reset mid-test:** assert `reset` at E40 → all outputs 0 at E40, no RAM enables afterwards. Then `start` → full run, `pass`=1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// Built-in self-test sequencer for dual_port_ram: write P0, verify, write ~P0, verify.
// Reports pass/fail plus the address, phase and read data of the first mismatch.
module ram_bist_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_phase,
  output logic [DATA_W-1:0] fail_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_we_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_re_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR0  = 3'd1;
  localparam logic [2:0] S_RD0  = 3'd2;
  localparam logic [2:0] S_DRN0 = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_RD1  = 3'd5;
  localparam logic [2:0] S_DRN1 = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [2:0]        LAT_LAST  = 3'(RD_LAT - 1);

  typedef struct packed {
    logic              vld;
    logic              ph;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } ent_t;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        lat_q, lat_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              fail_seen_q, fail_seen_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              fail_phase_q, fail_phase_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  ent_t [RD_LAT-1:0] pipe_q, pipe_d;

  logic              phase1;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] addr_ext;
  logic [DATA_W-1:0] pat;
  ent_t              new_ent;
  ent_t              chk_ent;
  ent_t [RD_LAT:0]   shift_w;
  logic              mismatch;

  always_comb begin
    phase1   = (state_q == S_WR1) || (state_q == S_RD1) || (state_q == S_DRN1);
    wr_en    = (state_q == S_WR0) || (state_q == S_WR1);
    rd_en    = (state_q == S_RD0) || (state_q == S_RD1);
    addr_ext = '0;
    addr_ext[ADDR_W-1:0] = addr_q;
    pat      = phase1 ? ~(seed_q ^ addr_ext) : (seed_q ^ addr_ext);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    seed_d       = seed_q;
    fail_seen_d  = fail_seen_q;
    fail_addr_d  = fail_addr_q;
    fail_phase_d = fail_phase_q;
    fail_data_d  = fail_data_q;

    // Each read carries its expected data alongside it; the top slot of the
    // widened shift word is the entry whose dout is valid this cycle.
    new_ent.vld  = rd_en;
    new_ent.ph   = phase1;
    new_ent.addr = addr_q;
    new_ent.exp  = pat;
    shift_w      = {pipe_q, new_ent};
    pipe_d       = shift_w[RD_LAT-1:0];
    chk_ent      = shift_w[RD_LAT];
    mismatch     = chk_ent.vld && (ram_dout != chk_ent.exp);

    if (mismatch && !fail_seen_q) begin
      fail_seen_d  = 1'b1;
      fail_addr_d  = chk_ent.addr;
      fail_phase_d = chk_ent.ph;
      fail_data_d  = ram_dout;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WR0;
          addr_d       = '0;
          lat_d        = '0;
          seed_d       = seed;
          fail_seen_d  = 1'b0;
          fail_addr_d  = '0;
          fail_phase_d = 1'b0;
          fail_data_d  = '0;
        end
      end
      S_WR0: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) state_d = S_RD0;
      end
      S_RD0: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRN0;
          lat_d   = '0;
        end
      end
      S_DRN0: begin
        lat_d = lat_q + 3'd1;
        if (lat_q == LAT_LAST) state_d = S_WR1;
      end
      S_WR1: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) state_d = S_RD1;
      end
      S_RD1: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRN1;
          lat_d   = '0;
        end
      end
      S_DRN1: begin
        lat_d = lat_q + 3'd1;
        if (lat_q == LAT_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      lat_q        <= '0;
      seed_q       <= '0;
      fail_seen_q  <= 1'b0;
      fail_addr_q  <= '0;
      fail_phase_q <= 1'b0;
      fail_data_q  <= '0;
      pipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      seed_q       <= seed_d;
      fail_seen_q  <= fail_seen_d;
      fail_addr_q  <= fail_addr_d;
      fail_phase_q <= fail_phase_d;
      fail_data_q  <= fail_data_d;
      pipe_q       <= pipe_d;
    end
  end

  always_comb begin
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    done        = (state_q == S_DONE);
    pass        = done && !fail_seen_q;
    fail_addr   = fail_addr_q;
    fail_phase  = fail_phase_q;
    fail_data   = fail_data_q;
    ram_we      = wr_en;
    ram_we_addr = wr_en ? addr_q : '0;
    ram_din     = wr_en ? pat : '0;
    ram_re      = rd_en;
    ram_re_addr = rd_en ? addr_q : '0;
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl with a fault-injectable RAM model.
module tb_ram_bist_ctrl;
  localparam int unsigned AW      = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned LAT     = 1;
  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned RUN_CYC = 4 * DEPTH + 2 * LAT;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] seed;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic          fail_phase;
  logic [DW-1:0] fail_data;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_we_addr, ram_re_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_phase(fail_phase), .fail_data(fail_data),
    .ram_we(ram_we), .ram_we_addr(ram_we_addr), .ram_din(ram_din),
    .ram_re(ram_re), .ram_re_addr(ram_re_addr), .ram_dout(ram_dout)
  );

  // RAM with per-address stuck-at-0 / stuck-at-1 masks applied on write
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] s0    [DEPTH];
  logic [DW-1:0] s1    [DEPTH];
  logic [DW-1:0] rd_sr [LAT];

  always @(posedge clk) begin
    if (ram_we) mem[ram_we_addr] <= (ram_din & ~s0[ram_we_addr]) | s1[ram_we_addr];
    rd_sr[0] <= mem[ram_re_addr];
    for (int i = LAT - 1; i > 0; i--) rd_sr[i] <= rd_sr[i-1];
  end
  assign ram_dout = rd_sr[LAT-1];

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic p; logic [AW-1:0] a; logic ph; logic [DW-1:0] d; } res_t;

  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  res_t          resq[$];
  res_t          exp_res;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] patt(input logic [DW-1:0] sd, input int p, input int a);
    logic [DW-1:0] v;
    v = sd ^ DW'(a);
    return (p == 1) ? ~v : v;
  endfunction

  // Outcome of a full test: the first address/phase, in sweep order, whose stored value differs
  function automatic res_t model(input logic [DW-1:0] sd);
    res_t r;
    logic [DW-1:0] want, got;
    r.p = 1'b1; r.a = '0; r.ph = 1'b0; r.d = '0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < DEPTH; a++) begin
        want = patt(sd, p, a);
        got  = (want & ~s0[a]) | s1[a];
        if (r.p && got != want) begin
          r.p = 1'b0; r.a = AW'(a); r.ph = (p == 1); r.d = got;
        end
      end
    return r;
  endfunction

  // Monitor: pops scoreboard entries whenever the DUT drives the RAM or finishes
  int unsigned ncyc = 0;
  int unsigned t0 = 0;
  logic prev_busy = 1'b0, prev_done = 1'b0;
  wr_t  mw;
  res_t mr;
  logic [AW-1:0] ma;

  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && !prev_busy) t0 = ncyc;
      if (ram_we && ram_re) chk("we_re_overlap", 1, 0);
      if (ram_we) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mw = wq.pop_front();
          chk("wr_addr", 32'(ram_we_addr), 32'(mw.a));
          chk("wr_data", 32'(ram_din), 32'(mw.d));
        end
      end else chk("wr_idle_drive", {ram_we_addr, ram_din}, 0);
      if (ram_re) begin
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          ma = rq.pop_front();
          chk("rd_addr", 32'(ram_re_addr), 32'(ma));
        end
      end else chk("rd_idle_drive", 32'(ram_re_addr), 0);
      if (done && !prev_done) begin
        chk("done_latency", ncyc - t0, RUN_CYC);
        chk("busy_at_done", 32'(busy), 0);
        if (resq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mr = resq.pop_front();
          chk("pass", 32'(pass), 32'(mr.p));
          chk("fail_addr", 32'(fail_addr), 32'(mr.a));
          chk("fail_phase", 32'(fail_phase), 32'(mr.ph));
          chk("fail_data", 32'(fail_data), 32'(mr.d));
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic flush();
    wq.delete(); rq.delete(); resq.delete();
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin s0[a] = '0; s1[a] = '0; end
  endtask

  task automatic launch(input logic [DW-1:0] sd);
    wr_t w;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w.a = AW'(a); w.d = patt(sd, p, a);
        wq.push_back(w);
      end
      for (int a = 0; a < DEPTH; a++) rq.push_back(AW'(a));
    end
    exp_res = model(sd);
    resq.push_back(exp_res);
    @(negedge clk);
    start = 1'b1; seed = sd;
    @(negedge clk);
    start = 1'b0; seed = DW'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2 * RUN_CYC) begin @(negedge clk); n++; end
    if (!done) begin
      chk("done_timeout", 0, 1);
      reset = 1'b1; flush();
      @(negedge clk); reset = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
      chk("done_hold", 32'(done), 1);
      chk("pass_hold", 32'(pass), 32'(exp_res.p));
      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, pass}, 0);
    chk({tag, "_fail"}, {fail_addr, fail_phase, fail_data}, 0);
    chk({tag, "_ram"}, {ram_we, ram_we_addr, ram_din, ram_re, ram_re_addr}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; seed = '0;
    clear_faults();
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Healthy RAM, seed 0x00 and 0xA5
    launch(8'h00); wait_done();
    launch(8'hA5); wait_done();

    // Stuck-0 on bit 3 at address 5: only the inverse pass sees it
    s0[5] = 8'h08;
    launch(8'h00); wait_done();
    chk("stuck_fail_data_const", 32'(fail_data), 32'h0000_00F2);
    clear_faults();

    // Two faults: the phase-0 one at address 2 must win
    s0[2] = 8'h02; s1[9] = 8'h80;
    launch(8'h00); wait_done();
    clear_faults();

    // Fault seen only on the very last compare
    s0[15] = 8'h80;
    launch(8'h00); wait_done();
    clear_faults();

    // start while busy is ignored
    launch(8'h11);
    repeat (19) @(negedge clk);
    start = 1'b1; seed = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-test after a phase-0 mismatch has been latched
    s0[3] = 8'h01;
    launch(8'h5A);
    repeat (39) @(negedge clk);
    reset = 1'b1; flush();
    @(negedge clk);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 0);
    clear_faults();
    launch(8'h5A); wait_done();

    // Randomized seeds and faults
    for (int it = 0; it < 8; it++) begin
      clear_faults();
      for (int f = 0; f < int'($urandom_range(0, 2)); f++) begin
        if ($urandom_range(0, 1) == 1) s0[$urandom_range(0, DEPTH - 1)] = DW'($urandom);
        else                           s1[$urandom_range(0, DEPTH - 1)] = DW'($urandom);
      end
      launch(DW'($urandom));
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
